// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  localparam int MAXW = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAXW-1:0] neg2c(
    input logic [MAXW-1:0] x
  );
    return ~x + MAXW'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_o
);

  logic [WIDTH:0] t;

  always_comb begin
    t   = {r_i, bit_i};
    q_o = t >= {1'b0, d_i};
    r_o = t[WIDTH-1:0];
    if (q_o) r_o = t[WIDTH-1:0] - d_i;
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed/unsigned restoring divider for the HI/LO unit.
// Quotient goes to low, remainder (dividend's sign) to high.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             div_end,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic             end_q, end_d;
  logic             zero_q, zero_d;

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_neg, r_neg;
  logic [WIDTH-1:0] r_nxt;
  logic             q_bit;

  // Magnitudes are unsigned WIDTH-bit, so |most-negative| fits.
  assign sa    = SIGNED_EN & signed_op & a[WIDTH-1];
  assign sb    = SIGNED_EN & signed_op & b[WIDTH-1];
  assign a_mag = sa ? WIDTH'(neg2c(MAXW'(a))) : a;
  assign b_mag = sb ? WIDTH'(neg2c(MAXW'(b))) : b;
  assign q_neg = WIDTH'(neg2c(MAXW'(dq_q)));
  assign r_neg = WIDTH'(neg2c(MAXW'(r_q)));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i   (r_q),
    .bit_i (dq_q[WIDTH-1]),
    .d_i   (dvs_q),
    .r_o   (r_nxt),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    high_d  = high_q;
    low_d   = low_q;
    end_d   = 1'b0;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (div) begin
          if (b == '0) begin
            end_d  = 1'b1;
            zero_d = 1'b1;
          end else begin
            dq_d    = a_mag;
            dvs_d   = b_mag;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            nq_d    = sa ^ sb;
            nr_d    = sa;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Dividend shifts out MSB first; quotient shifts in at LSB.
        dq_d  = {dq_q[WIDTH-2:0], q_bit};
        r_d   = r_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        low_d   = nq_q ? q_neg : dq_q;
        high_d  = nr_q ? r_neg : r_q;
        end_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      end_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      high_q  <= high_d;
      low_q   <= low_d;
      end_q   <= end_d;
      zero_q  <= zero_d;
    end
  end

  assign high     = high_q;
  assign low      = low_q;
  assign busy     = state_q != IDLE;
  assign div_end  = end_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus
// hand-written control sequences.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        div;
  logic        signed_op;
  logic [31:0] a, b;
  logic [31:0] high, low, high2, low2;
  logic        busy, div_end, div_zero;
  logic        busy2, div_end2, div_zero2;

  int total = 0;
  int bad   = 0;

  seq_divider #(
    .WIDTH     (32),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .high      (high),
    .low       (low),
    .busy      (busy),
    .div_end   (div_end),
    .div_zero  (div_zero)
  );

  seq_divider #(
    .WIDTH     (32),
    .SIGNED_EN (1'b0)
  ) dut_u (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .high      (high2),
    .low       (low2),
    .busy      (busy2),
    .div_end   (div_end2),
    .div_zero  (div_zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] ulo;
    logic [31:0] uhi;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Presents a start at the next posedge (E0), returns at the
  // negedge after E0 with div dropped.
  task automatic start_op(input logic [31:0] av,
                          input logic [31:0] bv,
                          input logic        s);
    a         = av;
    b         = bv;
    signed_op = s;
    div       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div = 1'b0;
  endtask

  // e0 = edges seen so far counting E0; returns in div_end cycle.
  task automatic wait_done(input int          e0,
                           input logic [31:0] lo,
                           input logic [31:0] hi,
                           input string       nm);
    int e;
    e = e0;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    while (!div_end && e < 80) begin
      @(negedge clk);
      e++;
    end
    chk({nm, " latency"}, e, 34);
    chk({nm, " low"}, low, lo);
    chk({nm, " high"}, high, hi);
    chk({nm, " busy_at_end"}, 32'(busy), 32'd0);
    chk({nm, " zero"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    bit seen;
    vt[0] = '{32'd7, 32'd2, 1'b0,
              32'd3, 32'd1, 32'd3, 32'd1};
    vt[1] = '{32'hFFFFFFF9, 32'd2, 1'b1,
              32'hFFFFFFFD, 32'hFFFFFFFF,
              32'h7FFFFFFC, 32'd1};
    vt[2] = '{32'd7, 32'hFFFFFFFE, 1'b1,
              32'hFFFFFFFD, 32'd1, 32'd0, 32'd7};
    vt[3] = '{32'hFFFFFFFF, 32'd2, 1'b0,
              32'h7FFFFFFF, 32'd1,
              32'h7FFFFFFF, 32'd1};
    vt[4] = '{32'hFFFFFFFF, 32'd2, 1'b1,
              32'd0, 32'hFFFFFFFF,
              32'h7FFFFFFF, 32'd1};
    vt[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
              32'h80000000, 32'd0,
              32'd0, 32'h80000000};
    vt[6] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1,
              32'd3, 32'hFFFFFFFF,
              32'd0, 32'hFFFFFFF9};
    vt[7] = '{32'd100, 32'd7, 1'b1,
              32'd14, 32'd2, 32'd14, 32'd2};
    vt[8] = '{32'h80000000, 32'd1, 1'b1,
              32'h80000000, 32'd0,
              32'h80000000, 32'd0};

    reset     = 1'b1;
    div       = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst high", high, 32'd0);
    chk("rst low", low, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst end", 32'(div_end), 32'd0);
    chk("rst zero", 32'(div_zero), 32'd0);

    for (int i = 0; i < 9; i++) begin
      start_op(vt[i].a, vt[i].b, vt[i].s);
      wait_done(1, vt[i].lo, vt[i].hi,
                $sformatf("vec%0d", i));
      chk($sformatf("vec%0d ulow", i), low2, vt[i].ulo);
      chk($sformatf("vec%0d uhigh", i), high2, vt[i].uhi);
      chk($sformatf("vec%0d uend", i),
          32'(div_end2), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i),
          32'(div_end), 32'd0);
    end

    // Divide by zero keeps previous result (80000000 / 0).
    start_op(32'd5, 32'd0, 1'b0);
    chk("dz end", 32'(div_end), 32'd1);
    chk("dz zero", 32'(div_zero), 32'd1);
    chk("dz busy", 32'(busy), 32'd0);
    chk("dz low", low, 32'h80000000);
    chk("dz high", high, 32'd0);
    @(negedge clk);
    chk("dz end pulse", 32'(div_end), 32'd0);
    chk("dz zero pulse", 32'(div_zero), 32'd0);
    chk("dz busy2", 32'(busy), 32'd0);

    // Start re-pulsed mid-operation with different operands.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    a   = 32'd1;
    b   = 32'd1;
    div = 1'b1;
    @(negedge clk);
    div = 1'b0;
    wait_done(11, 32'd14, 32'd2, "repulse");
    @(negedge clk);

    // Reset mid-operation aborts silently.
    start_op(32'd7, 32'd2, 1'b0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort low", low, 32'd0);
    chk("abort high", high, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (div_end) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort no end", 32'(seen), 32'd0);

    // Back-to-back: second start in the div_end cycle.
    start_op(32'd7, 32'd2, 1'b0);
    wait_done(1, 32'd3, 32'd1, "b2b first");
    start_op(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(1, 32'hFFFFFFFD, 32'hFFFFFFFF, "b2b second");
    @(negedge clk);
    chk("b2b pulse", 32'(div_end), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multicycle restoring divider for the processor datapath's HI/LO unit.
- Computes quotient into low and remainder into high for signed or unsigned operands. The mode is selectable per operation.
- Adds the following: start/busy handshake, start-ignored-while-busy, defined signed-overflow result, and a one-cycle done pulse.
- Driven by the control unit's div state; results feed the HI/LO registers.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- SIGNED_EN, 1, 1 = honour signed_op; 0 = force unsigned regardless of signed_op.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- div  input  1  start request, sampled on clk when idle
- signed_op  input  1  1 = two's-complement operands (qualified by SIGNED_EN)
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- high  output  WIDTH  remainder (registered)
- low  output  WIDTH  quotient (registered)
- busy  output  1  high while an operation is in progress
- div_end  output  1  one-cycle done pulse
- div_zero  output  1  one-cycle divide-by-zero flag, coincident with div_end

Behaviour:
- Reset (sync, active-high, dominates all else): state=IDLE; high=0, low=0, busy=0, div_end=0, div_zero=0; internal quotient, remainder and counter cleared. Reset mid-operation aborts it silently, with no div_end.
- States: IDLE, CALC, FIX.
- IDLE:
  - On div=1 at edge E0, latch sign flags and magnitudes (|a|, |b| when signed mode, else raw), then go to CALC with counter=WIDTH.
  - If b==0 at E0: stay IDLE, pulse div_end=1 and div_zero=1 for the cycle after E0; high/low unchanged.
- CALC: one quotient bit per cycle, MSB first.
  - Partial remainder R (WIDTH+1 bits) = {R, next dividend bit}.
  - If R ≥ divisor: R -= divisor and the quotient bit is 1.
  - Counter decrements; after WIDTH cycles go to FIX.
- FIX (one cycle):
  - Negate quotient if the operand signs differ.
  - Negate remainder if the dividend was negative, so the remainder takes the dividend's sign (truncating division).
  - Write low/high, pulse div_end, return to IDLE.
- Latency: div_end is high in the cycle following edge E(WIDTH+1); for WIDTH=32 the result is visible 34 edges after E0 counting E0. busy is 1 from the cycle after E0 until div_end is asserted, and 0 during the div_end cycle.
- div while busy: ignored. Operands are captured only at E0, so a/b may change freely afterwards.
- div asserted in the same cycle as div_end (state IDLE): accepted as a new start.
- Signed overflow (a=most-negative, b=−1, signed mode): low=most-negative, high=0, div_end normal, div_zero=0. This is natural two's-complement wrap and needs no special trap.
- Magnitude of most-negative: treat as unsigned 2^(WIDTH−1). The magnitude path must not overflow.
- div_end and div_zero are never high for more than one cycle.
- high/low hold their last result until the next successful completion or reset.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE/CALC/FIX)
  - counter width constant $clog2(WIDTH+1)
  - helper function for two's-complement negate.
- One natural sub-module, div_step: the combinational single-iteration compare/subtract (R, divisor → next R, q bit). It is instantiated once inside the FSM datapath.

Test Plan:
- Unsigned: a=7, b=2, signed_op=0 → after 34 edges: low=3, high=1, div_end pulse 1 cycle, busy 0 after.
- Signed: a=0xFFFFFFF9 (−7), b=2 → low=0xFFFFFFFD (−3), high=0xFFFFFFFF (−1). Also a=7, b=0xFFFFFFFE → low=0xFFFFFFFD, high=1.
- Unsigned large: a=0xFFFFFFFF, b=2, signed_op=0 → low=0x7FFFFFFF, high=1. The same operands with signed_op=1 and SIGNED_EN=0 give an identical result.
- Divide by zero: a=5, b=0 → next cycle div_zero=1 and div_end=1; busy never rises; high/low keep prior values.
- Overflow: a=0x80000000, b=0xFFFFFFFF, signed → low=0x80000000, high=0, div_zero=0.
- Control:
  - div re-pulsed at cycle 10 of an operation → ignored, original result correct.
  - reset at cycle 15 → all outputs 0, no div_end.
  - back-to-back start in the div_end cycle → second result correct 34 edges later.
